sevenseg_scan_driver: RTL

Display-side consumer for the board's counter/value outputs. It takes a 16-bit value (4 hex digits) and drives a 4-digit multiplexed common-anode seven-segment display. The refresh rate comes from a clock-enable tick derived from the single system clock; no derived clocks are used. The value is latched once per scan frame so a value changing mid-frame never shows a mixed frame.

---
 rtl/sevenseg_scan_driver_if.sv | 22 ++
 rtl/sevenseg_scan_driver.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_driver_if.sv
// Display-side bus for the seven-segment scan driver: value/control in,
// multiplexed anode/segment drive out.
interface sevenseg_scan_driver_if;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_start;

  modport master (
    output en, value, dp, blank_lz,
    input  an, seg, dp_n, frame_start
  );

  modport slave (
    input  en, value, dp, blank_lz,
    output an, seg, dp_n, frame_start
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// 4-digit multiplexed common-anode seven-segment driver with per-frame value
// latching, anti-ghosting guard band and optional leading-zero blanking.
module sevenseg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  sevenseg_scan_driver_if.slave bus
);

  localparam int unsigned    CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} slot_t;

  slot_t         slot, slot_nxt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [15:0]   value_q;
  logic [3:0]    dp_q;

  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          lz_hit;
  logic          blank;
  logic [6:0]    seg_hex;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dpn_d;

  always_comb tick = (cnt == CNT_LAST);

  // State register: prescaler, digit slot and per-frame latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      slot            <= DIG0;
      value_q         <= '0;
      dp_q            <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      cnt             <= tick ? '0 : cnt + 1'b1;
      slot            <= slot_nxt;
      bus.frame_start <= tick && (slot == DIG3);
      if (tick && (slot == DIG3)) begin
        value_q <= bus.value;
        dp_q    <= bus.dp;
      end
    end
  end

  always_comb begin
    slot_nxt = slot;
    if (tick) begin
      unique case (slot)
        DIG0:    slot_nxt = DIG1;
        DIG1:    slot_nxt = DIG2;
        DIG2:    slot_nxt = DIG3;
        default: slot_nxt = DIG0;
      endcase
    end
  end

  // Leading-zero test looks at this nibble and every more significant one
  always_comb begin
    idx    = slot;
    nib    = value_q[3:0];
    lz_hit = 1'b0;
    unique case (slot)
      DIG0: nib = value_q[3:0];
      DIG1: begin
        nib    = value_q[7:4];
        lz_hit = (value_q[15:4] == '0);
      end
      DIG2: begin
        nib    = value_q[11:8];
        lz_hit = (value_q[15:8] == '0);
      end
      default: begin
        nib    = value_q[15:12];
        lz_hit = (value_q[15:12] == '0);
      end
    endcase
  end

  always_comb begin
    seg_hex = 7'h7F;
    unique case (nib)
      4'h0: seg_hex = 7'h40;
      4'h1: seg_hex = 7'h79;
      4'h2: seg_hex = 7'h24;
      4'h3: seg_hex = 7'h30;
      4'h4: seg_hex = 7'h19;
      4'h5: seg_hex = 7'h12;
      4'h6: seg_hex = 7'h02;
      4'h7: seg_hex = 7'h78;
      4'h8: seg_hex = 7'h00;
      4'h9: seg_hex = 7'h10;
      4'hA: seg_hex = 7'h08;
      4'hB: seg_hex = 7'h03;
      4'hC: seg_hex = 7'h46;
      4'hD: seg_hex = 7'h21;
      4'hE: seg_hex = 7'h06;
      default: seg_hex = 7'h0E;
    endcase
  end

  // Output decode; en and blank_lz act live, not per frame
  always_comb begin
    blank = !bus.en || (cnt < CNT_GUARD) || (bus.blank_lz && lz_hit);
    an_d  = '1;
    seg_d = '1;
    dpn_d = 1'b1;
    if (!blank) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = seg_hex;
      dpn_d = ~dp_q[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an   <= '1;
      bus.seg  <= '1;
      bus.dp_n <= 1'b1;
    end else begin
      bus.an   <= an_d;
      bus.seg  <= seg_d;
      bus.dp_n <= dpn_d;
    end
  end

endmodule
